addsub_arbiter: RTL and testbench
=================================

Name: addsub_arbiter

Overview:
- Shares one 64-bit adder_subtractor instance among NREQ requesters, with round-robin arbitration.
- Two-stage pipeline:
  - Stage 1 is the operand register. It drives the shared unit.
  - Stage 2 is the result register. It feeds one response channel tagged with the requester ID.
- Sits between the ALU-issue clients and the shared arithmetic resource.
- Provides valid/ready backpressure end to end.

Parameters:
- NREQ, 4, number of requesters (2..8).
- IDW, $clog2(NREQ), width of the requester ID tag (derived; do not override).

Ports:
- clk  input  1  single clock; all state updates on the rising edge.
- rst_n  input  1  asynchronous, active-low reset.
- req_valid  input  NREQ  per-requester request valid.
- req_ready  output  NREQ  per-requester accept; one-hot or zero.
- req_a  input  64*NREQ  operand a, packed; requester i occupies [64*i +: 64].
- req_b  input  64*NREQ  operand b, packed the same way.
- req_sub  input  NREQ  1 = a-b, 0 = a+b.
- rsp_valid  output  1  result valid.
- rsp_ready  input  1  downstream accepts the result.
- rsp_id  output  IDW  requester index of the result.
- rsp_s  output  64  sum or difference.
- rsp_cout  output  1  carry-out (add) or not-borrow (sub).
- busy  output  1  either pipeline stage is occupied.

Behaviour:
- Reset (async assert, sync deassert handled upstream):
  - s1_valid=0, rsp_valid=0.
  - rr_ptr=0.
  - rsp_id=0, rsp_s=0, rsp_cout=0.
  - busy=0, req_ready=0.
- Stall logic:
  - s2_adv = !rsp_valid || rsp_ready.
  - s1_free = !s1_valid || s2_adv.
- Arbitration (combinational):
  - Search requesters starting at rr_ptr, wrapping modulo NREQ.
  - The first i with req_valid[i]=1 is the grant.
  - req_ready[i] = grant[i] && s1_free.
- Accept:
  - Occurs on an edge where req_valid[i] && req_ready[i].
  - Captures a, b, sub and id=i into stage 1; sets s1_valid=1.
  - Sets rr_ptr = (i+1) mod NREQ.
  - rr_ptr is unchanged when nothing is accepted.
- Stage 1 → stage 2:
  - On an edge where s1_valid && s2_adv: capture the shared unit's s and cout into rsp_s/rsp_cout, copy id to rsp_id, set rsp_valid=1.
  - If s1_valid=0 && rsp_ready: clear rsp_valid=0.
  - If s1_valid=0 and the stage does not advance: hold.
- Latency and throughput:
  - Latency is 2 edges: the acceptance edge, then rsp_valid is high after the next edge.
  - Throughput is 1 op per cycle while rsp_ready=1.
- Response hold rule: while rsp_valid && !rsp_ready, rsp_id, rsp_s and rsp_cout hold stable, and stage 1 holds.
- Simultaneous events:
  - Accept into stage 1 and advance stage 1 → stage 2 on the same edge is legal: a full pipeline with rsp_ready=1 keeps flowing.
- Stall:
  - With both stages full and rsp_ready=0, all req_ready=0.
  - The granted requester must keep req_valid and its data stable (standard valid/ready rule). The arbiter does not latch the grant across stalls.
- Fairness: a continuously requesting client waits at most NREQ-1 acceptances.
- Arithmetic is that of adder_subtractor:
  - s = a + (b ^ {64{sub}}) + sub, modulo 2^64.
  - cout is bit 64 of that sum.
  - Example: 0-1 gives s=FFFF_FFFF_FFFF_FFFF, cout=0.
- busy = s1_valid || rsp_valid.
- Reset mid-operation: all in-flight operations are discarded with no response. rr_ptr returns to 0.

Optional Feature:
- ADDSUB_ARB_OVF_EN defined:
  - Adds output rsp_ovf (1 bit), registered alongside rsp_s.
  - Signed overflow = (a[63] == b_eff[63]) && (s[63] != a[63]), where b_eff = b ^ {64{sub}}.
  - rsp_ovf resets to 0.
- Undefined: the port is absent and no overflow logic exists.

Decomposition:
- Package addsub_arb_pkg:
  - DATA_W=64 constant.
  - Stage-1 struct typedef: a, b, sub, id.
  - Response struct typedef: id, s, cout, [ovf].
- Sub-module rr_arbiter (parameter N):
  - Inputs: req[N], ptr.
  - Outputs: one-hot grant[N], encoded gidx.
  - Purely combinational.
- adder_subtractor: instantiated once, unchanged.

Test Plan:
- Reset, then a single request from requester 2: a=5, b=3, sub=0, rsp_ready=1 → 2 edges later rsp_valid=1, rsp_id=2, rsp_s=8, rsp_cout=0.
- Requester 0: a=0, b=1, sub=1 → rsp_s=FFFF_FFFF_FFFF_FFFF, rsp_cout=0. Then a=7, b=7, sub=1 → rsp_s=0, rsp_cout=1.
- All 4 requesters hold valid for 8 cycles with rsp_ready=1 → grant order 0,1,2,3,0,1,2,3; a response every cycle; IDs in the same order.
- Full pipeline, rsp_ready=0 for 5 cycles:
  - req_ready=0 throughout.
  - rsp_s/rsp_id stable throughout.
  - On release, both queued results drain on consecutive cycles with nothing lost or duplicated.
- rst_n asserted while both stages are valid → rsp_valid=0 and busy=0 immediately (async). After release, the next grant starts from requester 0.
- ADDSUB_ARB_OVF_EN: a=7FFF_FFFF_FFFF_FFFF, b=1, sub=0 → rsp_ovf=1. a=8000_0000_0000_0000, b=1, sub=1 → rsp_ovf=1. a=1, b=1, sub=0 → rsp_ovf=0.

Source files
------------

// File: rtl/addsub_arb_pkg.sv
// Shared types and constants for the addsub_arbiter slice.
// The optional overflow flag in rsp_t is present only when ADDSUB_ARB_OVF_EN is defined.
package addsub_arb_pkg;

  localparam int unsigned DATA_W   = 64;
  // Largest requester ID width (NREQ <= 8)
  localparam int unsigned ID_MAX_W = 3;

  // Stage-1 operand register payload
  typedef struct packed {
    logic [DATA_W-1:0]   a;
    logic [DATA_W-1:0]   b;
    logic                sub;
    logic [ID_MAX_W-1:0] id;
  } s1_t;

  // Stage-2 response register payload
  typedef struct packed {
    logic [ID_MAX_W-1:0] id;
    logic [DATA_W-1:0]   s;
    logic                cout;
`ifdef ADDSUB_ARB_OVF_EN
    logic                ovf;
`endif
  } rsp_t;

`ifdef ADDSUB_ARB_OVF_EN
  // Signed overflow: operands share a sign and the result sign differs
  function automatic logic signed_ovf(input logic a_msb, input logic beff_msb,
                                      input logic s_msb);
    return (a_msb == beff_msb) && (s_msb != a_msb);
  endfunction
`endif

endpackage

// File: rtl/adder_subtractor.sv
// Combinational W-bit adder/subtractor: s = a + (b ^ {W{sub}}) + sub.
// Ports: a, b (operands), sub (1 = a-b), s (result), cout (carry / not-borrow).
module adder_subtractor #(
  parameter int unsigned W = 64
) (
  input  logic [W-1:0] a,
  input  logic [W-1:0] b,
  input  logic         sub,
  output logic [W-1:0] s,
  output logic         cout
);

  logic [W:0] sum;

  assign sum  = {1'b0, a} + {1'b0, b ^ {W{sub}}} + (W+1)'(sub);
  assign s    = sum[W-1:0];
  assign cout = sum[W];

endmodule

// File: rtl/rr_arbiter.sv
// Combinational round-robin arbiter: first asserted req at or after ptr, wrapping.
// Ports: req (requests), ptr (search start), grant (one-hot or zero), gidx (grant index).
module rr_arbiter #(
  parameter int unsigned N  = 4,
  localparam int unsigned IW = $clog2(N)
) (
  input  logic [N-1:0]  req,
  input  logic [IW-1:0] ptr,
  output logic [N-1:0]  grant,
  output logic [IW-1:0] gidx
);

  int unsigned idx;
  logic        found;

  // Linear scan from ptr; the first hit wins
  always_comb begin
    grant = '0;
    gidx  = '0;
    found = 1'b0;
    idx   = 0;
    for (int unsigned k = 0; k < N; k++) begin
      idx = 32'(ptr) + k;
      if (idx >= N) idx = idx - N;
      if (!found && req[idx]) begin
        found      = 1'b1;
        grant[idx] = 1'b1;
        gidx       = IW'(idx);
      end
    end
  end

endmodule

// File: rtl/addsub_arbiter.sv
// Round-robin sharing of one 64-bit adder_subtractor among NREQ requesters.
// Stage 1 holds operands driving the shared unit; stage 2 holds the tagged response.
// Ports: clk, rst_n (async active-low); req_valid/req_ready/req_a/req_b/req_sub
// per-requester request channel; rsp_valid/rsp_ready/rsp_id/rsp_s/rsp_cout response
// channel; busy (either stage occupied). Defining ADDSUB_ARB_OVF_EN adds rsp_ovf.
module addsub_arbiter
  import addsub_arb_pkg::*;
#(
  parameter int unsigned NREQ = 4,
  localparam int unsigned IDW = $clog2(NREQ)
) (
  input  logic                   clk,
  input  logic                   rst_n,
  input  logic [NREQ-1:0]        req_valid,
  output logic [NREQ-1:0]        req_ready,
  input  logic [DATA_W*NREQ-1:0] req_a,
  input  logic [DATA_W*NREQ-1:0] req_b,
  input  logic [NREQ-1:0]        req_sub,
  output logic                   rsp_valid,
  input  logic                   rsp_ready,
  output logic [IDW-1:0]         rsp_id,
  output logic [DATA_W-1:0]      rsp_s,
  output logic                   rsp_cout,
  output logic                   busy
`ifdef ADDSUB_ARB_OVF_EN
  ,output logic                  rsp_ovf
`endif
);

  s1_t             s1_q, s1_d;
  logic            s1_valid_q, s1_valid_d;
  rsp_t            rsp_q, rsp_d;
  logic            rsp_valid_q, rsp_valid_d;
  logic [IDW-1:0]  rr_ptr_q, rr_ptr_d;

  logic [NREQ-1:0] grant;
  logic [IDW-1:0]  gidx;
  logic            s2_adv, s1_free, accept;
  logic [DATA_W-1:0] add_s;
  logic            add_cout;
  logic            id_unused;

  rr_arbiter #(.N(NREQ)) u_rr (
    .req   (req_valid),
    .ptr   (rr_ptr_q),
    .grant (grant),
    .gidx  (gidx)
  );

  adder_subtractor #(.W(DATA_W)) u_addsub (
    .a    (s1_q.a),
    .b    (s1_q.b),
    .sub  (s1_q.sub),
    .s    (add_s),
    .cout (add_cout)
  );

  // Pipeline stall terms
  assign s2_adv    = !rsp_valid_q || rsp_ready;
  assign s1_free   = !s1_valid_q || s2_adv;
  assign req_ready = grant & {NREQ{s1_free}};
  assign accept    = s1_free && (|req_valid);

  // Next-state for both stages and the round-robin pointer
  always_comb begin
    s1_d        = s1_q;
    s1_valid_d  = s1_valid_q;
    rsp_d       = rsp_q;
    rsp_valid_d = rsp_valid_q;
    rr_ptr_d    = rr_ptr_q;

    if (accept) begin
      s1_d.a     = req_a[DATA_W*32'(gidx) +: DATA_W];
      s1_d.b     = req_b[DATA_W*32'(gidx) +: DATA_W];
      s1_d.sub   = req_sub[gidx];
      s1_d.id    = ID_MAX_W'(gidx);
      s1_valid_d = 1'b1;
      rr_ptr_d   = (gidx == IDW'(NREQ-1)) ? '0 : gidx + IDW'(1);
    end else if (s2_adv) begin
      s1_valid_d = 1'b0;
    end

    if (s1_valid_q && s2_adv) begin
      rsp_d.id    = s1_q.id;
      rsp_d.s     = add_s;
      rsp_d.cout  = add_cout;
`ifdef ADDSUB_ARB_OVF_EN
      rsp_d.ovf   = signed_ovf(s1_q.a[DATA_W-1], s1_q.b[DATA_W-1] ^ s1_q.sub,
                               add_s[DATA_W-1]);
`endif
      rsp_valid_d = 1'b1;
    end else if (s2_adv) begin
      rsp_valid_d = 1'b0;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      s1_q        <= '0;
      s1_valid_q  <= 1'b0;
      rsp_q       <= '0;
      rsp_valid_q <= 1'b0;
      rr_ptr_q    <= '0;
    end else begin
      s1_q        <= s1_d;
      s1_valid_q  <= s1_valid_d;
      rsp_q       <= rsp_d;
      rsp_valid_q <= rsp_valid_d;
      rr_ptr_q    <= rr_ptr_d;
    end
  end

  // ID bits above IDW stay zero for small NREQ
  assign id_unused = ^rsp_q.id;

  assign rsp_valid = rsp_valid_q;
  assign rsp_id    = rsp_q.id[IDW-1:0];
  assign rsp_s     = rsp_q.s;
  assign rsp_cout  = rsp_q.cout;
  assign busy      = s1_valid_q || rsp_valid_q;
`ifdef ADDSUB_ARB_OVF_EN
  assign rsp_ovf   = rsp_q.ovf;
`endif

endmodule

// File: tb/tb_addsub_arbiter.sv
// Directed self-checking bench for addsub_arbiter (NREQ = 4).
module tb_addsub_arbiter;

  logic         clk = 1'b0;
  logic         rst_n = 1'b1;
  logic [3:0]   req_valid;
  logic [3:0]   req_ready;
  logic [255:0] req_a;
  logic [255:0] req_b;
  logic [3:0]   req_sub;
  logic         rsp_valid;
  logic         rsp_ready;
  logic [1:0]   rsp_id;
  logic [63:0]  rsp_s;
  logic         rsp_cout;
  logic         busy;
`ifdef ADDSUB_ARB_OVF_EN
  logic         rsp_ovf;
`endif

  int n_cmp  = 0;
  int n_fail = 0;

  addsub_arbiter #(.NREQ(4)) dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .req_valid (req_valid),
    .req_ready (req_ready),
    .req_a     (req_a),
    .req_b     (req_b),
    .req_sub   (req_sub),
    .rsp_valid (rsp_valid),
    .rsp_ready (rsp_ready),
    .rsp_id    (rsp_id),
    .rsp_s     (rsp_s),
    .rsp_cout  (rsp_cout),
    .busy      (busy)
`ifdef ADDSUB_ARB_OVF_EN
    ,.rsp_ovf  (rsp_ovf)
`endif
  );

  always #5 clk = ~clk;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic set_op(input int i, input logic [63:0] a, input logic [63:0] b,
                        input logic sub);
    req_a[64*i +: 64] = a;
    req_b[64*i +: 64] = b;
    req_sub[i]        = sub;
  endtask

  task automatic test_reset();
    req_valid = '0; req_a = '0; req_b = '0; req_sub = '0; rsp_ready = 1'b1;
    #1 rst_n = 1'b0;
    #12;
    n_cmp++; if (rsp_valid !== 1'b0) begin n_fail++; $display("FAIL reset_rsp_valid: got %b want 0", rsp_valid); end
    n_cmp++; if (busy !== 1'b0) begin n_fail++; $display("FAIL reset_busy: got %b want 0", busy); end
    n_cmp++; if (req_ready !== 4'b0000) begin n_fail++; $display("FAIL reset_req_ready: got %b want 0000", req_ready); end
    n_cmp++; if (rsp_id !== 2'd0) begin n_fail++; $display("FAIL reset_rsp_id: got %0d want 0", rsp_id); end
    n_cmp++; if (rsp_s !== 64'd0) begin n_fail++; $display("FAIL reset_rsp_s: got %h want 0", rsp_s); end
    n_cmp++; if (rsp_cout !== 1'b0) begin n_fail++; $display("FAIL reset_rsp_cout: got %b want 0", rsp_cout); end
    @(negedge clk) rst_n = 1'b1;
    tick();
  endtask

  task automatic test_single();
    set_op(2, 64'd5, 64'd3, 1'b0);
    req_valid = 4'b0100;
    #1;
    n_cmp++; if (req_ready !== 4'b0100) begin n_fail++; $display("FAIL single_req_ready: got %b want 0100", req_ready); end
    tick();
    req_valid = '0;
    n_cmp++; if (rsp_valid !== 1'b0) begin n_fail++; $display("FAIL single_early_valid: got %b want 0", rsp_valid); end
    n_cmp++; if (busy !== 1'b1) begin n_fail++; $display("FAIL single_busy: got %b want 1", busy); end
    tick();
    n_cmp++; if (rsp_valid !== 1'b1) begin n_fail++; $display("FAIL single_rsp_valid: got %b want 1", rsp_valid); end
    n_cmp++; if (rsp_id !== 2'd2) begin n_fail++; $display("FAIL single_rsp_id: got %0d want 2", rsp_id); end
    n_cmp++; if (rsp_s !== 64'd8) begin n_fail++; $display("FAIL single_rsp_s: got %h want 8", rsp_s); end
    n_cmp++; if (rsp_cout !== 1'b0) begin n_fail++; $display("FAIL single_rsp_cout: got %b want 0", rsp_cout); end
    tick();
    n_cmp++; if (rsp_valid !== 1'b0) begin n_fail++; $display("FAIL single_drain: got %b want 0", rsp_valid); end
    n_cmp++; if (busy !== 1'b0) begin n_fail++; $display("FAIL single_idle: got %b want 0", busy); end
  endtask

  task automatic test_sub();
    set_op(0, 64'd0, 64'd1, 1'b1);
    req_valid = 4'b0001;
    #1;
    n_cmp++; if (req_ready !== 4'b0001) begin n_fail++; $display("FAIL sub_req_ready: got %b want 0001", req_ready); end
    tick();
    set_op(0, 64'd7, 64'd7, 1'b1);
    tick();
    req_valid = '0;
    n_cmp++; if (rsp_s !== 64'hFFFF_FFFF_FFFF_FFFF) begin n_fail++; $display("FAIL sub_neg_s: got %h want ffffffffffffffff", rsp_s); end
    n_cmp++; if (rsp_cout !== 1'b0) begin n_fail++; $display("FAIL sub_neg_cout: got %b want 0", rsp_cout); end
    n_cmp++; if (rsp_id !== 2'd0) begin n_fail++; $display("FAIL sub_neg_id: got %0d want 0", rsp_id); end
    tick();
    n_cmp++; if (rsp_valid !== 1'b1) begin n_fail++; $display("FAIL sub_zero_valid: got %b want 1", rsp_valid); end
    n_cmp++; if (rsp_s !== 64'd0) begin n_fail++; $display("FAIL sub_zero_s: got %h want 0", rsp_s); end
    n_cmp++; if (rsp_cout !== 1'b1) begin n_fail++; $display("FAIL sub_zero_cout: got %b want 1", rsp_cout); end
    tick();
    n_cmp++; if (rsp_valid !== 1'b0) begin n_fail++; $display("FAIL sub_drain: got %b want 0", rsp_valid); end
  endtask

  task automatic test_reset_mid();
    rsp_ready = 1'b0;
    set_op(0, 64'd1, 64'd1, 1'b0);
    req_valid = 4'b0001;
    tick();
    tick();
    req_valid = '0;
    n_cmp++; if (busy !== 1'b1) begin n_fail++; $display("FAIL mid_busy_before: got %b want 1", busy); end
    n_cmp++; if (rsp_valid !== 1'b1) begin n_fail++; $display("FAIL mid_valid_before: got %b want 1", rsp_valid); end
    #1 rst_n = 1'b0;
    #1;
    n_cmp++; if (rsp_valid !== 1'b0) begin n_fail++; $display("FAIL mid_rsp_valid: got %b want 0", rsp_valid); end
    n_cmp++; if (busy !== 1'b0) begin n_fail++; $display("FAIL mid_busy: got %b want 0", busy); end
    @(negedge clk) rst_n = 1'b1;
    rsp_ready = 1'b1;
    set_op(1, 64'd9, 64'd9, 1'b0);
    set_op(2, 64'd9, 64'd9, 1'b0);
    set_op(3, 64'd9, 64'd9, 1'b0);
    req_valid = 4'b1111;
    #1;
    n_cmp++; if (req_ready !== 4'b0001) begin n_fail++; $display("FAIL mid_ptr_restart: got %b want 0001", req_ready); end
    tick();
    req_valid = '0;
    tick();
    n_cmp++; if (rsp_valid !== 1'b1 || rsp_id !== 2'd0 || rsp_s !== 64'd2) begin
      n_fail++; $display("FAIL mid_after_rsp: got v=%b id=%0d s=%h want v=1 id=0 s=2", rsp_valid, rsp_id, rsp_s); end
    tick();
    n_cmp++; if (busy !== 1'b0) begin n_fail++; $display("FAIL mid_idle: got %b want 0", busy); end
  endtask

  task automatic test_round_robin();
    int          exp_id;
    logic [63:0] exp_s;
    logic [3:0]  exp_rdy;
    rst_n = 1'b0;
    #1 rst_n = 1'b1;
    rsp_ready = 1'b1;
    for (int i = 0; i < 4; i++) set_op(i, 64'(i * 16), 64'd1, 1'b0);
    for (int e = 1; e <= 10; e++) begin
      req_valid = (e <= 8) ? 4'b1111 : 4'b0000;
      #1;
      if (e <= 8) begin
        exp_rdy = 4'b0001 << ((e - 1) % 4);
        n_cmp++; if (req_ready !== exp_rdy) begin n_fail++; $display("FAIL rr_grant_%0d: got %b want %b", e, req_ready, exp_rdy); end
      end
      if (e >= 3) begin
        exp_id = (e - 3) % 4;
        exp_s  = 64'(exp_id * 16 + 1);
        n_cmp++; if (rsp_valid !== 1'b1 || rsp_id !== 2'(exp_id) || rsp_s !== exp_s) begin
          n_fail++; $display("FAIL rr_rsp_%0d: got v=%b id=%0d s=%h want v=1 id=%0d s=%h", e, rsp_valid, rsp_id, rsp_s, exp_id, exp_s); end
      end
      tick();
    end
    n_cmp++; if (rsp_valid !== 1'b0) begin n_fail++; $display("FAIL rr_drain: got %b want 0", rsp_valid); end
  endtask

  task automatic test_back_to_back_stall();
    rsp_ready = 1'b1;
    set_op(0, 64'd10, 64'd1, 1'b0);
    set_op(1, 64'd20, 64'd2, 1'b1);
    req_valid = 4'b0011;
    #1;
    n_cmp++; if (req_ready !== 4'b0001) begin n_fail++; $display("FAIL stall_first_grant: got %b want 0001", req_ready); end
    tick();
    rsp_ready = 1'b0;
    #1;
    n_cmp++; if (req_ready !== 4'b0010) begin n_fail++; $display("FAIL stall_second_grant: got %b want 0010", req_ready); end
    tick();
    set_op(0, 64'd30, 64'd5, 1'b0);
    req_valid = 4'b0001;
    for (int c = 0; c < 5; c++) begin
      #1;
      n_cmp++; if (req_ready !== 4'b0000) begin n_fail++; $display("FAIL stall_ready_%0d: got %b want 0000", c, req_ready); end
      n_cmp++; if (rsp_valid !== 1'b1 || rsp_id !== 2'd0 || rsp_s !== 64'd11) begin
        n_fail++; $display("FAIL stall_hold_%0d: got v=%b id=%0d s=%h want v=1 id=0 s=b", c, rsp_valid, rsp_id, rsp_s); end
      tick();
    end
    rsp_ready = 1'b1;
    #1;
    n_cmp++; if (req_ready !== 4'b0001) begin n_fail++; $display("FAIL stall_release_grant: got %b want 0001", req_ready); end
    tick();
    req_valid = '0;
    n_cmp++; if (rsp_valid !== 1'b1 || rsp_id !== 2'd1 || rsp_s !== 64'd18) begin
      n_fail++; $display("FAIL stall_drain1: got v=%b id=%0d s=%h want v=1 id=1 s=12", rsp_valid, rsp_id, rsp_s); end
    tick();
    n_cmp++; if (rsp_valid !== 1'b1 || rsp_id !== 2'd0 || rsp_s !== 64'd35) begin
      n_fail++; $display("FAIL stall_drain2: got v=%b id=%0d s=%h want v=1 id=0 s=23", rsp_valid, rsp_id, rsp_s); end
    tick();
    n_cmp++; if (rsp_valid !== 1'b0 || busy !== 1'b0) begin
      n_fail++; $display("FAIL stall_empty: got v=%b busy=%b want 0 0", rsp_valid, busy); end
  endtask

`ifdef ADDSUB_ARB_OVF_EN
  task automatic test_ovf();
    logic [63:0] va [3];
    logic [63:0] vb [3];
    logic        vsub [3];
    logic [63:0] es [3];
    logic        eovf [3];
    va[0] = 64'h7FFF_FFFF_FFFF_FFFF; vb[0] = 64'd1; vsub[0] = 1'b0; es[0] = 64'h8000_0000_0000_0000; eovf[0] = 1'b1;
    va[1] = 64'h8000_0000_0000_0000; vb[1] = 64'd1; vsub[1] = 1'b1; es[1] = 64'h7FFF_FFFF_FFFF_FFFF; eovf[1] = 1'b1;
    va[2] = 64'd1;                   vb[2] = 64'd1; vsub[2] = 1'b0; es[2] = 64'd2;                   eovf[2] = 1'b0;
    rsp_ready = 1'b1;
    for (int v = 0; v < 3; v++) begin
      set_op(0, va[v], vb[v], vsub[v]);
      req_valid = 4'b0001;
      tick();
      req_valid = '0;
      tick();
      n_cmp++; if (rsp_valid !== 1'b1 || rsp_s !== es[v] || rsp_ovf !== eovf[v]) begin
        n_fail++; $display("FAIL ovf_%0d: got v=%b s=%h ovf=%b want v=1 s=%h ovf=%b", v, rsp_valid, rsp_s, rsp_ovf, es[v], eovf[v]); end
    end
    tick();
  endtask
`endif

  initial begin
    test_reset();
    test_single();
    test_sub();
    test_reset_mid();
    test_round_robin();
    test_back_to_back_stall();
`ifdef ADDSUB_ARB_OVF_EN
    test_ovf();
`endif
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end

endmodule
